// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register with a one-entry skid
// buffer, flush (bubble insertion) and NOP bubble payload.
// Optional macro PIPE_STAGE_PERF_EN adds saturating stall/bubble counters.
module pipe_stage_reg #(
    parameter int unsigned       WIDTH        = 32,
    parameter logic [WIDTH-1:0]  BUBBLE_VALUE = WIDTH'(32'h0000_0013),
    parameter int unsigned       PERF_W       = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] bubble_cycles
`endif
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             acc, pop;

    if (PERF_W < 1) begin : g_perf_w_chk
        $error("PERF_W must be at least 1");
    end

    // in_ready comes straight from the skid flop, so out_ready never reaches it
    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_valid_q ? main_data_q : BUBBLE_VALUE;

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    // Next state of the (main, skid) entries; flush empties the stage
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            // Data flops keep stale contents; out_data is masked by main_valid
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case ({main_valid_q, skid_valid_q})
                2'b00: begin
                    if (acc) begin
                        main_valid_d = 1'b1;
                        main_data_d  = in_data;
                    end
                end
                2'b10: begin
                    if (acc && !pop) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data;
                    end else if (acc && pop) begin
                        main_data_d  = in_data;
                    end else if (pop) begin
                        main_valid_d = 1'b0;
                    end
                end
                2'b11: begin
                    // in_ready is low here, so only a pop can move state
                    if (pop) begin
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset dominating flush and handshakes
    always_ff @(posedge clock) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= BUBBLE_VALUE;
            skid_data_q  <= BUBBLE_VALUE;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    // A skid entry without a main entry would reorder beats
    illegal_state_a: assert property (@(posedge clock) disable iff (reset)
        !(skid_valid_q && !main_valid_q));

`ifdef PIPE_STAGE_PERF_EN
    logic [PERF_W-1:0] stall_q, bubble_q;

    assign stall_cycles  = stall_q;
    assign bubble_cycles = bubble_q;

    // Saturating counters; only reset clears them, flush does not
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready && stall_q != {PERF_W{1'b1}})
                stall_q <= stall_q + PERF_W'(1);
            if (!out_valid && bubble_q != {PERF_W{1'b1}})
                bubble_q <= bubble_q + PERF_W'(1);
        end
    end
`else
    // Counters and their ports are not built in this configuration
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed test-plan sequences plus random traffic, checked
// against a queue-based model of a two-deep FIFO stage.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cycles, bubble_cycles;
`endif

    always #5 clock = ~clock;

    pipe_stage_reg #(.WIDTH(32), .BUBBLE_VALUE(NOP), .PERF_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .bubble_cycles (bubble_cycles)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference: beats in flight, oldest first, at most two
    logic [31:0] m_q[$];
    int unsigned m_stall = 0;
    int unsigned m_bubble = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Check outputs mid-cycle, then advance the model at the clock edge
    task automatic tick();
        logic        ev;
        logic        acc, pop;
        @(negedge clock);
        ev = (m_q.size() > 0);
        chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
        chk("in_ready",  {31'b0, in_ready},  {31'b0, m_q.size() < 2});
        chk("out_data",  out_data, ev ? m_q[0] : NOP);
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cycles",  stall_cycles,  m_stall);
        chk("bubble_cycles", bubble_cycles, m_bubble);
`endif
        @(posedge clock);
        acc = in_valid && (m_q.size() < 2);
        pop = ev && out_ready;
        if (reset) begin
            m_q.delete();
            m_stall = 0;
            m_bubble = 0;
        end else begin
            if (ev && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (!ev && m_bubble != 32'hFFFF_FFFF) m_bubble++;
            if (flush) m_q.delete();
            else begin
                if (pop) void'(m_q.pop_front());
                if (acc) m_q.push_back(in_data);
            end
        end
        #1;
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv,
                         input logic [31:0] d, input logic ordy);
        reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        tick();
    endtask

    initial begin
        // Bring DUT and model into a known state before checking anything
        reset = 1'b1;
        @(posedge clock);
        m_q.delete();
        #1;

        // Reset held two cycles with a live beat offered
        drive(1, 0, 1, 32'hDEAD_BEEF, 0);
        drive(1, 0, 1, 32'hDEAD_BEEF, 0);
        @(negedge clock);
        chk("reset_bubble", out_data, NOP);
        chk("reset_ready", {31'b0, in_ready}, 32'd1);
        #6;

        // Streaming at full rate
        drive(0, 0, 1, 32'h1000, 1);
        drive(0, 0, 1, 32'h1004, 1);
        drive(0, 0, 1, 32'h1008, 1);
        drive(0, 0, 0, 32'h0,    1);
        drive(0, 0, 0, 32'h0,    1);

        // Backpressure: ONE with A, accept B into skid, then drain
        drive(0, 0, 1, 32'hA, 0);
        drive(0, 0, 1, 32'hB, 0);
        drive(0, 0, 1, 32'hE, 0);   // in_ready low: E must be dropped
        @(negedge clock);
        chk("bp_hold_a", out_data, 32'hA);
        chk("bp_full", {31'b0, in_ready}, 32'd0);
        #6;
        drive(0, 0, 0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 1);

        // Flush from FULL with C offered
        drive(0, 0, 1, 32'hA, 0);
        drive(0, 0, 1, 32'hB, 0);
        drive(0, 1, 1, 32'hC, 0);
        @(negedge clock);
        chk("flush_bubble", out_data, NOP);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        #6;
        drive(0, 0, 0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 1);

        // Reset from FULL, then a single beat
        drive(0, 0, 1, 32'hA, 0);
        drive(0, 0, 1, 32'hB, 0);
        drive(1, 0, 0, 32'h0, 0);
        drive(0, 0, 1, 32'h55, 1);
        @(negedge clock);
        chk("post_reset_55", out_data, 32'h55);
        #6;
        drive(0, 0, 0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 1);

        // Perf profile: 3 idle then valid beats held against out_ready=0
        drive(1, 0, 0, 32'h0, 0);
        repeat (3) drive(0, 0, 0, 32'h0, 0);
        drive(0, 0, 1, 32'h77, 0);
        repeat (4) drive(0, 0, 0, 32'h0, 0);
`ifdef PIPE_STAGE_PERF_EN
        @(negedge clock);
        chk("perf_stall4", stall_cycles, 32'd4);
        chk("perf_bubble4", bubble_cycles, 32'd4);
        #6;
`endif
        drive(0, 1, 0, 32'h0, 0);   // flush must not clear counters

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
                  $urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
